// File: rtl/cd_reset_sequencer.sv
// Reset sequencer for banks of async-clear registers. Clears assert at once, release is synchronised
// to CK, all clears are held for HOLD_CYCLES, then released one by one STAGGER edges apart.
module cd_reset_sequencer #(
    parameter string GSR         = "ENABLED",
    parameter int    SYNC_STAGES = 2,
    parameter int    HOLD_CYCLES = 16,
    parameter int    STAGGER     = 4,
    parameter int    NUM_OUT     = 4
) (
    input  logic               CK,
    input  logic               CDN,
    input  logic               GSRNET,
    input  logic               PURNET,
    input  logic               SOFT_REQ,
    output logic               SOFT_ACK,
    output logic [NUM_OUT-1:0] CD,
    output logic               READY,
    output logic [1:0]         STATE
);

    localparam int CNT_SPAN = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
    localparam int CW       = $clog2(CNT_SPAN) + 1;
    localparam int IW       = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER - 1);
    localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUT - 1);
    localparam logic          GSR_EN    = (GSR == "ENABLED");

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'b00,
        ST_HOLD    = 2'b01,
        ST_RELEASE = 2'b10,
        ST_RUN     = 2'b11
    } state_t;

    logic                   rst_n_s;
    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_inc_s;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   hist_q, hist_d;
    logic [NUM_OUT-1:0]     cd_q, cd_d;
    logic                   ready_q, ready_d;
    logic                   ack_q, ack_d;

    // GSRNET only participates when the global set/reset is enabled
    assign rst_n_s   = CDN & PURNET & (GSRNET | ~GSR_EN);
    assign cnt_inc_s = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + {{(CW-1){1'b0}}, 1'b1};

    // Next-state logic for the sequencer, clears, handshake and release synchroniser
    always_comb begin
        state_d = state_q;
        sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b1};
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        hist_d  = SOFT_REQ;
        cd_d    = cd_q;
        ready_d = ready_q;
        ack_d   = 1'b0;
        case (state_q)
            ST_ASSERT: begin
                if (sync_q[SYNC_STAGES-1]) begin
                    state_d = ST_HOLD;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d   = {CW{1'b0}};
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cd_d[0] = 1'b0;
                    cnt_d   = {CW{1'b0}};
                    idx_d   = IW'(1);
                    if (NUM_OUT == 1) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ST_RELEASE: begin
                if (cnt_q == STAG_LAST) begin
                    cd_d[idx_q] = 1'b0;
                    cnt_d       = {CW{1'b0}};
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                    end else begin
                        idx_d = idx_q + {{(IW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ST_RUN: begin
                // Only a fresh 0->1 on SOFT_REQ restarts the hold/release sequence
                if (SOFT_REQ && !hist_q) begin
                    cd_d    = {NUM_OUT{1'b1}};
                    ready_d = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ST_HOLD;
                    cnt_d   = {CW{1'b0}};
                    idx_d   = {IW{1'b0}};
                end else begin
                    cnt_d = {CW{1'b0}};
                end
            end
            default: begin
                state_d = ST_ASSERT;
                cnt_d   = {CW{1'b0}};
                idx_d   = {IW{1'b0}};
                cd_d    = {NUM_OUT{1'b1}};
                ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears asynchronously with no clock required
    always_ff @(posedge CK or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q <= ST_ASSERT;
            sync_q  <= {SYNC_STAGES{1'b0}};
            cnt_q   <= {CW{1'b0}};
            idx_q   <= {IW{1'b0}};
            hist_q  <= 1'b1;
            cd_q    <= {NUM_OUT{1'b1}};
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            hist_q  <= hist_d;
            cd_q    <= cd_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
        end
    end

    assign CD       = cd_q;
    assign READY    = ready_q;
    assign SOFT_ACK = ack_q;
    assign STATE    = state_q;

endmodule

// File: tb/tb_cd_reset_sequencer.sv
// Self-checking bench: three sequencer configurations against an edge-count reference model,
// directed power-up/glitch/soft-reset/GSR phases followed by randomized traffic.
module tb_cd_reset_sequencer;

    logic       CK = 1'b0;
    logic       clk_run = 1'b0;
    logic       CDN, GSRNET, PURNET, SOFT_REQ;
    logic [3:0] cd_a, cd_b;
    logic [0:0] cd_c;
    logic       ack_a, ack_b, ack_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic [1:0] st_a, st_b, st_c;

    int n_checks = 0;
    int n_fail   = 0;

    // per-instance configuration: SYNC, HOLD, STAGGER, NUM_OUT, GSR enabled
    int p_s[3]   = '{2, 2, 2};
    int p_h[3]   = '{16, 16, 1};
    int p_st[3]  = '{4, 4, 1};
    int p_n[3]   = '{4, 4, 1};
    bit p_gsr[3] = '{1'b1, 1'b0, 1'b1};

    // model: edges since release, edge of HOLD entry, edge of last ack, SOFT_REQ history
    int rel_m[3];
    int h_m[3];
    int ack_m[3];
    bit hist_m[3];

    cd_reset_sequencer #(.GSR("ENABLED"), .SYNC_STAGES(2), .HOLD_CYCLES(16), .STAGGER(4), .NUM_OUT(4)) dut_a (
        .CK(CK), .CDN(CDN), .GSRNET(GSRNET), .PURNET(PURNET), .SOFT_REQ(SOFT_REQ),
        .SOFT_ACK(ack_a), .CD(cd_a), .READY(rdy_a), .STATE(st_a));

    cd_reset_sequencer #(.GSR("DISABLED"), .SYNC_STAGES(2), .HOLD_CYCLES(16), .STAGGER(4), .NUM_OUT(4)) dut_b (
        .CK(CK), .CDN(CDN), .GSRNET(GSRNET), .PURNET(PURNET), .SOFT_REQ(SOFT_REQ),
        .SOFT_ACK(ack_b), .CD(cd_b), .READY(rdy_b), .STATE(st_b));

    cd_reset_sequencer #(.GSR("ENABLED"), .SYNC_STAGES(2), .HOLD_CYCLES(1), .STAGGER(1), .NUM_OUT(1)) dut_c (
        .CK(CK), .CDN(CDN), .GSRNET(GSRNET), .PURNET(PURNET), .SOFT_REQ(SOFT_REQ),
        .SOFT_ACK(ack_c), .CD(cd_c), .READY(rdy_c), .STATE(st_c));

    always begin
        #5;
        if (clk_run) CK = ~CK;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit eff_rstn(int j);
        return CDN & PURNET & (p_gsr[j] ? GSRNET : 1'b1);
    endfunction

    // 0 ASSERT, 1 HOLD, 2 RELEASE, 3 RUN as a function of edges since release
    function automatic int state_at(int j, int e);
        if (e < h_m[j]) return 0;
        if (e < h_m[j] + p_h[j]) return 1;
        if (e < h_m[j] + p_h[j] + (p_n[j] - 1) * p_st[j]) return 2;
        return 3;
    endfunction

    task automatic model_async();
        for (int j = 0; j < 3; j++) begin
            if (!eff_rstn(j)) begin
                rel_m[j]  = 0;
                h_m[j]    = p_s[j] + 1;
                ack_m[j]  = -1;
                hist_m[j] = 1'b1;
            end
        end
    endtask

    task automatic model_edge();
        for (int j = 0; j < 3; j++) begin
            if (eff_rstn(j)) begin
                int st;
                st = state_at(j, rel_m[j]);
                rel_m[j]++;
                if (st == 3 && SOFT_REQ && !hist_m[j]) begin
                    h_m[j]   = rel_m[j];
                    ack_m[j] = rel_m[j];
                end
                hist_m[j] = SOFT_REQ;
            end
        end
    endtask

    task automatic check_all();
        for (int j = 0; j < 3; j++) begin
            logic [3:0] exp_cd;
            logic [3:0] obs_cd;
            logic       obs_rdy, obs_ack;
            logic [1:0] obs_st;
            int         st;
            exp_cd = 4'h0;
            for (int i = 0; i < p_n[j]; i++)
                exp_cd[i] = (rel_m[j] < h_m[j] + p_h[j] + i * p_st[j]);
            st = state_at(j, rel_m[j]);
            case (j)
                0: begin obs_cd = cd_a; obs_rdy = rdy_a; obs_ack = ack_a; obs_st = st_a; end
                1: begin obs_cd = cd_b; obs_rdy = rdy_b; obs_ack = ack_b; obs_st = st_b; end
                default: begin obs_cd = {3'b000, cd_c}; obs_rdy = rdy_c; obs_ack = ack_c; obs_st = st_c; end
            endcase
            check_eq($sformatf("cd%0d", j), 32'(obs_cd), 32'(exp_cd));
            check_eq($sformatf("ready%0d", j), 32'(obs_rdy), 32'(st == 3));
            check_eq($sformatf("state%0d", j), 32'(obs_st), 32'(st));
            check_eq($sformatf("ack%0d", j), 32'(obs_ack), 32'(ack_m[j] == rel_m[j]));
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CK);
            model_edge();
            #1;
            check_all();
        end
    endtask

    // 1 ns low pulse on one reset source: 0 CDN, 1 GSRNET, 2 PURNET
    task automatic pulse_rst(input int which);
        #2;
        case (which)
            0: CDN = 1'b0;
            1: GSRNET = 1'b0;
            default: PURNET = 1'b0;
        endcase
        model_async();
        #1;
        check_all();
        CDN    = 1'b1;
        GSRNET = 1'b1;
        PURNET = 1'b1;
    endtask

    initial begin
        CDN = 1'b1; GSRNET = 1'b1; PURNET = 1'b1; SOFT_REQ = 1'b0;
        #2;
        CDN = 1'b0;
        model_async();
        #3;
        check_all();
        check_eq("pwr_cd_noclk", 32'(cd_a), 32'h0000000F);
        clk_run = 1'b1;
        tick(3);
        CDN = 1'b1;
        tick(24);
        pulse_rst(0);
        tick(40);
        check_eq("run_ready", 32'(rdy_a), 32'd1);

        SOFT_REQ = 1'b1;
        tick(40);
        SOFT_REQ = 1'b0;
        tick(2);
        SOFT_REQ = 1'b1;
        tick(3);
        SOFT_REQ = 1'b0;
        tick(1);
        SOFT_REQ = 1'b1;
        tick(8);
        SOFT_REQ = 1'b0;
        tick(32);

        pulse_rst(1);
        tick(40);
        pulse_rst(2);
        tick(40);

        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 7) == 0) SOFT_REQ = ~SOFT_REQ;
            if ($urandom_range(0, 299) == 0) pulse_rst($urandom_range(0, 2));
            tick(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
